// File: rtl/i_img_pkg.sv
// Shared constants and types for the raster read path (image buffer -> pixel stream).
package i_img_pkg;

    localparam int DIM_W  = 13;
    localparam int ADDR_W = 2 * DIM_W;
    localparam int PIX_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic sol;
        logic eol;
        logic eof;
    } px_tag_t;

endpackage

// File: rtl/i_skid_fifo.sv
// Two-entry skid FIFO between the buffer read return and the pixel output handshake.
module i_skid_fifo #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/i_raster_reader.sv
// Raster-order image buffer reader streaming tagged pixels over valid/ready.
// Define I_RASTER_HFLIP_EN to read each row right-to-left (horizontal mirror).
module i_raster_reader
    import i_img_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_sol,
    output logic              px_eol,
    output logic              px_eof,
    output logic              busy,
    output logic              done,
    output logic              err_dim,
    output rd_state_t         state_dbg
);

    // Output handshake: a pixel transfers on a rising edge where px_valid & px_ready;
    // px_valid never depends on px_ready, and data/tags hold while stalled.

    rd_state_t         state_q;
    logic [DIM_W-1:0]  width_q, height_q, col_q, row_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q;
    px_tag_t           tag_q;
    logic              busy_q, done_q, err_q;

    logic [1:0]        fifo_count;
    logic [PIX_W+2:0]  fifo_data;
    px_tag_t           out_tag;
    logic              pop;
    logic [2:0]        occ;
    logic              issue;
    logic              col_last, row_last;

    assign px_valid = (fifo_count != 2'd0);
    assign pop      = px_valid & px_ready;
    // Slots already committed after this cycle's pop; keeps buffered + in-flight <= 2.
    assign occ      = 3'(fifo_count) + 3'(rd_q) - 3'(pop);
    assign issue    = (state_q == READ) && (occ < 3'd2);
    assign col_last = (col_q == width_q - DIM_W'(1));
    assign row_last = (row_q == height_q - DIM_W'(1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            tag_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            rd_q   <= issue;
            tag_q  <= '{sol: (col_q == '0), eol: col_last, eof: col_last & row_last};
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (img_width == '0 || img_height == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            width_q  <= img_width;
                            height_q <= img_height;
                            col_q    <= '0;
                            row_q    <= '0;
`ifdef I_RASTER_HFLIP_EN
                            addr_q   <= ADDR_W'(img_width) - ADDR_W'(1);
`else
                            addr_q   <= '0;
`endif
                            busy_q   <= 1'b1;
                            state_q  <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + DIM_W'(1);
`ifdef I_RASTER_HFLIP_EN
                            addr_q <= addr_q + ADDR_W'({width_q, 1'b0}) - ADDR_W'(1);
`else
                            addr_q <= addr_q + ADDR_W'(1);
`endif
                            if (row_last) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            col_q <= col_q + DIM_W'(1);
`ifdef I_RASTER_HFLIP_EN
                            addr_q <= addr_q - ADDR_W'(1);
`else
                            addr_q <= addr_q + ADDR_W'(1);
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_tag.eof) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    i_skid_fifo #(.W(PIX_W + 3)) u_fifo (
        .clk         (clk),
        .n_rst       (n_rst),
        .push_i      (rd_q),
        .push_data_i ({rd_data, tag_q}),
        .pop_i       (pop),
        .data_o      (fifo_data),
        .count_o     (fifo_count)
    );

    assign {px_data, out_tag} = fifo_data;
    assign px_sol    = out_tag.sol;
    assign px_eol    = out_tag.eol;
    assign px_eof    = out_tag.eof;
    assign rd_en     = issue;
    assign rd_addr   = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_dim   = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_i_raster_reader.sv
// Directed bench for i_raster_reader; expectations follow I_RASTER_HFLIP_EN when defined.
module tb_i_raster_reader;
    import i_img_pkg::*;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  img_width = '0;
    logic [DIM_W-1:0]  img_height = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data = '0;
    logic [PIX_W-1:0]  px_data;
    logic              px_valid;
    logic              px_ready = 1'b0;
    logic              px_sol, px_eol, px_eof;
    logic              busy, done, err_dim;
    rd_state_t         state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    i_raster_reader dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_sol     (px_sol),
        .px_eol     (px_eol),
        .px_eof     (px_eof),
        .busy       (busy),
        .done       (done),
        .err_dim    (err_dim),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] pix_of(input int addr);
        return 8'((addr * 13) + (addr >> 8) + 5);
    endfunction

    // Image buffer model: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= pix_of(int'(rd_addr));
    end

    function automatic int exp_addr(input int k, input int w);
        int r, c;
        r = k / w;
        c = k % w;
`ifdef I_RASTER_HFLIP_EN
        return r * w + (w - 1 - c);
`else
        return r * w + c;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic zero_dim(input int w, input int h);
        @(negedge clk);
        img_width = DIM_W'(w); img_height = DIM_W'(h); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("err_pulse", err_dim, 1);
        check("err_quiet", {rd_en, busy, px_valid}, 0);
        @(negedge clk);
        #1;
        check("err_one_cycle", err_dim, 0);
        check("err_no_read", {rd_en, busy, px_valid}, 0);
        check("err_state", state_dbg, IDLE);
    endtask

    // mode 0: px_ready held high; mode 1: px_ready pattern 1,0,0,1
    task automatic run_frame(input int w, input int h, input int mode, input int rst_at);
        int total, n_rd, n_px, eof_iter, first_rd, last_rd, col;
        bit fin, seen_v, held_v;
        logic [31:0] held;
        total = w * h;
        n_rd = 0; n_px = 0; eof_iter = -10; first_rd = -1; last_rd = -1;
        fin = 0; seen_v = 0; held_v = 0; held = '0;
        @(negedge clk);
        img_width = DIM_W'(w); img_height = DIM_W'(h); start = 1'b1; px_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_set", busy, 1);
        for (int iter = 0; iter < total * 4 + 20 && !fin; iter++) begin
            if (rst_at >= 0 && n_px == rst_at) begin
                n_rst = 1'b0; px_ready = 1'b0;
                @(negedge clk);
                n_rst = 1'b1;
                #1;
                check("rst_addr", rd_addr, 0);
                check("rst_outs", {rd_en, px_valid, px_data, px_sol, px_eol, px_eof, busy, done, err_dim}, 0);
                check("rst_state", state_dbg, IDLE);
                return;
            end
            if (iter == 4) start = 1'b0;
            px_ready = (mode == 0) ? 1'b1 : ((iter % 4 == 0) || (iter % 4 == 3));
            #1;
            check("err_busy", err_dim, 0);
            if (rd_en) begin
                check("rd_addr", rd_addr, exp_addr(n_rd, w));
                if (mode == 0 && n_rd > 0) check("rd_consec", iter, last_rd + 1);
                if (n_rd == 0) first_rd = iter;
                last_rd = iter;
                n_rd++;
            end
            if (held_v) check("stall_hold", {px_valid, px_sol, px_eol, px_eof, px_data}, held);
            if (px_valid && !seen_v) begin
                seen_v = 1;
                if (mode == 0) check("first_lat", iter, first_rd + 2);
            end
            if (iter == eof_iter + 1) begin
                check("done", done, 1);
                check("busy_clr", busy, 0);
                fin = 1;
            end else begin
                check("done_quiet", done, 0);
            end
            if (px_valid && px_ready && !fin) begin
                col = n_px % w;
                check("px_data", px_data, pix_of(exp_addr(n_px, w)));
                check("px_tags", {px_sol, px_eol, px_eof},
                      {(col == 0), (col == w - 1), (n_px == total - 1)});
                if (n_px == total - 1) eof_iter = iter;
                n_px++;
            end
            held_v = px_valid && !px_ready;
            held = 32'({px_valid, px_sol, px_eol, px_eof, px_data});
            if (rd_en) check("outstanding", 32'((n_rd - n_px) <= 2), 1);
            // a start (with zero width) while busy must be ignored
            if (mode == 1 && iter == 3) begin
                start = 1'b1; img_width = '0;
            end
            if (!fin) @(negedge clk);
        end
        check("frame_done", fin, 1);
        check("px_count", n_px, total);
        @(negedge clk);
        #1;
        check("done_pulse", done, 0);
        check("idle_state", state_dbg, IDLE);
    endtask

    initial begin
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", {rd_en, px_valid, busy, done, err_dim}, 0);
        check("reset_state", state_dbg, IDLE);
        n_rst = 1'b1;

        run_frame(4, 3, 0, -1);
        run_frame(10, 2, 1, -1);
        zero_dim(0, 5);
        zero_dim(5, 0);
        run_frame(1, 1, 0, -1);
        run_frame(8191, 1, 0, -1);
        run_frame(100, 100, 0, 57);
        run_frame(3, 2, 0, -1);
        run_frame(4, 2, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i_raster_reader.md
Name: i_raster_reader

Overview:
Read-side counterpart of the image write indexing (column/row counters). Walks a stored image in raster order and issues single-cycle-latency reads to the image buffer. Streams pixels downstream over a valid/ready handshake with start-of-line, end-of-line and end-of-frame markers. Sits between the image buffer and the processing pipeline.

Parameters:
DIM_W, 13, width of img_width/img_height and of the row/column counters
ADDR_W, 26, image buffer address width (2*DIM_W)
PIX_W, 8, pixel width

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
img_width  in  DIM_W  pixels per row; sampled on accepted start
img_height  in  DIM_W  rows per frame; sampled on accepted start
rd_en  out  1  buffer read strobe
rd_addr  out  ADDR_W  buffer read address, valid with rd_en
rd_data  in  PIX_W  buffer data, valid exactly 1 cycle after rd_en
px_data  out  PIX_W  output pixel
px_valid  out  1  output valid
px_ready  in  1  downstream ready
px_sol  out  1  px_data is column 0 of its row
px_eol  out  1  px_data is the last column of its row
px_eof  out  1  px_data is the last pixel of the frame
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the eof pixel transfers
err_dim  out  1  one-cycle pulse: start rejected, zero dimension

Behaviour:
- Reset: sampled on rising clk while n_rst=0; has priority over all other inputs, including mid-frame.
  - All outputs 0; counters, address and FIFO cleared; FSM to IDLE.
  - An in-flight read's data is discarded.
- FSM states IDLE, READ, DRAIN.
- IDLE:
  - start with width=0 or height=0: err_dim=1 next cycle, remain IDLE, no reads.
  - Otherwise latch dims, col=0, row=0, addr=0; busy=1 next cycle; go to READ.
- READ: issue a read when (fifo_count + inflight - pop) < 2, where pop = px_valid & px_ready.
  - Per issued read: addr += 1, col += 1.
  - At col = width-1, col wraps to 0 and row += 1.
  - Issuing the read for (width-1, height-1) goes to DRAIN.
  - Address is generated incrementally; no multiplier.
- Tags: sol/eol/eof are computed at issue and travel with the read through a 1-deep pipeline stage into the FIFO.
- Width=1: sol and eol are both 1 on every pixel. Width=1 and height=1: sol, eol and eof all 1.
- DRAIN:
  - No reads issued.
  - When the eof pixel transfers (valid & ready & eof): done=1 for one cycle, busy=0 in that same next cycle, go to IDLE.
- start while busy: ignored; no error pulse.
- Output FIFO (2-entry skid):
  - px_valid = fifo non-empty.
  - px_data and tags stable while px_valid & !px_ready.
  - Throughput is 1 pixel/clk with px_ready held high.
  - First px_valid appears 2 cycles after the first rd_en.
- A simultaneous push and pop never overflows or underflows.
- Dimension changes while busy have no effect (latched copies are used).

Optional Feature:
Macro I_RASTER_HFLIP_EN (horizontal mirror).
- Defined: each row is read right-to-left.
  - Start addr = width-1.
  - Within a row, addr -= 1.
  - At row wrap, addr += 2*width-1.
  - sol/eol still mark the first/last pixel emitted in the row.
- Undefined: left-to-right order as above; flip logic is absent.

Decomposition:
- Package i_img_pkg holds:
  - constants DIM_W, ADDR_W, PIX_W;
  - typedef enum logic [1:0] rd_state_t {IDLE, READ, DRAIN};
  - typedef struct px_tag_t {sol, eol, eof}.
- One sub-module, i_skid_fifo: 2-entry, PIX_W+3 wide, push/pop/count.
- Counters and FSM live in i_raster_reader.

Test Plan:
- 4x3 frame, px_ready=1:
  - 12 rd_en with rd_addr 0..11 on consecutive cycles.
  - px_sol on pixels 0, 4 and 8; px_eol on pixels 3, 7 and 11; px_eof only on pixel 11.
  - done pulses once, 1 cycle after pixel 11 transfers; busy clears in that same cycle.
- 10x2 frame, px_ready toggled 1,0,0,1 repeating:
  - No pixel is lost or duplicated; px_data equals the memory model at addr 0..19.
  - px_data and tags stay stable during stalls.
  - Never more than 2 outstanding reads plus buffered pixels.
- width=0, height=5 start: err_dim=1 for 1 cycle; rd_en, busy and px_valid stay 0. Same check for width=5, height=0.
- 1x1 frame: single read at addr 0; pixel has sol=eol=eof=1; done follows. Then 8191x1 frame: eol only at addr 8190.
- 100x100 frame, n_rst=0 at pixel 57 for 1 cycle:
  - All outputs 0 next cycle and FSM in IDLE.
  - A new start reads from addr 0 with sol=1.
- I_RASTER_HFLIP_EN build, 4x2 frame: addresses 3,2,1,0,7,6,5,4; sol on addr 3 and 7; eol on addr 0 and 4.
